// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I-subset multi-cycle controller: FSM states,
// opcodes, datapath mux selects and ALU operation codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_FAULT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // States that hold a memory access open and are subject to the wait bound.
    function automatic logic is_mem_wait_state(input state_t st);
        return (st == S_FETCH) || (st == S_MEM_READ) || (st == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded memory-ready wait counter: flags a timeout when WAIT_MAX cycles have
// elapsed in a memory state without the port reporting ready.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(WAIT_MAX - 32'd1);

    logic [7:0] count_r;

    // Count stalled cycles; any completion or non-memory state returns to zero,
    // so every memory state is entered with a cleared count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= 8'd0;
        end else if (active && !ready) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= 8'd0;
        end
    end

    // A ready on the final allowed cycle still counts as a normal completion.
    assign timeout = active && !ready && (count_r == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I-subset datapath with bounded memory waits
// and a sticky fault. Optional MULTICYCLE_CTRL_PERF_EN adds cycle/retire counters.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_zero,
    input  logic        in_mem_ready,
    output logic        out_pc_write,
    output logic        out_ir_write,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_mem_sel_data,
    output logic [1:0]  out_alu_src_a,
    output logic [1:0]  out_alu_src_b,
    output logic [1:0]  out_alu_op,
    output logic [1:0]  out_result_src,
    output logic        out_fault,
    output logic [3:0]  out_state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] out_cycles,
    output logic [31:0] out_retired
`endif
);

    state_t state_r;
    state_t next_s;
    logic   pc_write_s;
    logic   ir_write_s;
    logic   reg_write_s;
    logic   mem_write_s;
    logic   timeout_s;

    mem_wait_timer #(
        .WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (is_mem_wait_state(state_r)),
        .ready   (in_mem_ready),
        .timeout (timeout_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_s           = state_r;
        pc_write_s       = 1'b0;
        ir_write_s       = 1'b0;
        reg_write_s      = 1'b0;
        mem_write_s      = 1'b0;
        out_mem_read     = 1'b0;
        out_mem_sel_data = 1'b0;
        out_alu_src_a    = SRC_A_PC;
        out_alu_src_b    = SRC_B_RS2;
        out_alu_op       = ALU_ADD;
        out_result_src   = RES_ALU_OUT;
        out_fault        = 1'b0;
        case (state_r)
            S_FETCH: begin
                out_mem_read   = 1'b1;
                out_alu_src_b  = SRC_B_FOUR;
                out_result_src = RES_ALU;
                if (in_mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    next_s     = S_DECODE;
                end else if (timeout_s) begin
                    next_s = S_FAULT;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                out_alu_src_a = SRC_A_OLD_PC;
                out_alu_src_b = SRC_B_IMM;
                case (in_opcode)
                    OP_LOAD, OP_STORE: next_s = S_MEM_ADDR;
                    OP_RTYPE:          next_s = S_EXEC_R;
                    OP_ITYPE:          next_s = S_EXEC_I;
                    OP_BRANCH:         next_s = S_BRANCH;
                    OP_JAL:            next_s = S_JAL;
                    default:           next_s = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                out_alu_src_a = SRC_A_RS1;
                out_alu_src_b = SRC_B_IMM;
                if (in_opcode == OP_STORE) begin
                    next_s = S_MEM_WRITE;
                end else begin
                    next_s = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                out_mem_read     = 1'b1;
                out_mem_sel_data = 1'b1;
                if (in_mem_ready) begin
                    next_s = S_MEM_WB;
                end else if (timeout_s) begin
                    next_s = S_FAULT;
                end else begin
                    next_s = S_MEM_READ;
                end
            end
            S_MEM_WB: begin
                out_result_src = RES_MEM;
                reg_write_s    = 1'b1;
                next_s         = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_s      = 1'b1;
                out_mem_sel_data = 1'b1;
                if (in_mem_ready) begin
                    next_s = S_FETCH;
                end else if (timeout_s) begin
                    next_s = S_FAULT;
                end else begin
                    next_s = S_MEM_WRITE;
                end
            end
            S_EXEC_R: begin
                out_alu_src_a = SRC_A_RS1;
                out_alu_src_b = SRC_B_RS2;
                out_alu_op    = ALU_FUNCT;
                next_s        = S_ALU_WB;
            end
            S_EXEC_I: begin
                out_alu_src_a = SRC_A_RS1;
                out_alu_src_b = SRC_B_IMM;
                out_alu_op    = ALU_FUNCT;
                next_s        = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                next_s      = S_FETCH;
            end
            S_BRANCH: begin
                out_alu_src_a = SRC_A_RS1;
                out_alu_op    = ALU_SUB;
                case (in_funct3)
                    F3_BEQ: begin
                        pc_write_s = in_zero;
                        next_s     = S_FETCH;
                    end
                    F3_BNE: begin
                        pc_write_s = !in_zero;
                        next_s     = S_FETCH;
                    end
                    default: next_s = S_FAULT;
                endcase
            end
            S_JAL: begin
                out_alu_src_a = SRC_A_OLD_PC;
                out_alu_src_b = SRC_B_FOUR;
                pc_write_s    = 1'b1;
                next_s        = S_ALU_WB;
            end
            S_FAULT: begin
                out_fault = 1'b1;
                next_s    = S_FAULT;
            end
            default: begin
                next_s = S_FAULT;
            end
        endcase
    end

    // Write strobes are suppressed asynchronously while reset is held.
    assign out_pc_write  = pc_write_s && rst;
    assign out_ir_write  = ir_write_s && rst;
    assign out_reg_write = reg_write_s && rst;
    assign out_mem_write = mem_write_s && rst;
    assign out_state     = state_r;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire_s;

    assign retire_s = (next_s == S_FETCH) &&
                      ((state_r == S_MEM_WB) || (state_r == S_MEM_WRITE) ||
                       (state_r == S_ALU_WB) || (state_r == S_BRANCH));

    // Performance counters; both wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cycles  <= 32'd0;
            out_retired <= 32'd0;
        end else begin
            if (state_r != S_FAULT) begin
                out_cycles <= out_cycles + 32'd1;
            end else begin
                out_cycles <= out_cycles;
            end
            if (retire_s) begin
                out_retired <= out_retired + 32'd1;
            end else begin
                out_retired <= out_retired;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven directed bench for multicycle_controller, plus hand-written
// sequences for reset, fault stickiness, wait timeout and optional perf counters.
module tb_multicycle_controller;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        zero;
        logic        ready;
        logic [3:0]  exp_state;
        logic [14:0] exp_ctl;
    } vec_t;

    // ctl = {pc_write, ir_write, reg_write, mem_read, mem_write, mem_sel,
    //        src_a, src_b, alu_op, result_src, fault}
    localparam logic [14:0] C_FETCH     = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0};
    localparam logic [14:0] C_FETCH_RDY = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0};
    localparam logic [14:0] C_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0};
    localparam logic [14:0] C_MEM_ADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0};
    localparam logic [14:0] C_MEM_READ  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] C_MEM_WB    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,1'b0};
    localparam logic [14:0] C_MEM_WRITE = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] C_EXEC_R    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0};
    localparam logic [14:0] C_EXEC_I    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,2'b00,1'b0};
    localparam logic [14:0] C_ALU_WB    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0};
    localparam logic [14:0] C_BRANCH    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,1'b0};
    localparam logic [14:0] C_BRANCH_TK = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,1'b0};
    localparam logic [14:0] C_JAL       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,2'b00,1'b0};
    localparam logic [14:0] C_FAULT     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1};

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_zero;
    logic        in_mem_ready;
    logic        out_pc_write;
    logic        out_ir_write;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_mem_sel_data;
    logic [1:0]  out_alu_src_a;
    logic [1:0]  out_alu_src_b;
    logic [1:0]  out_alu_op;
    logic [1:0]  out_result_src;
    logic        out_fault;
    logic [3:0]  out_state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] out_cycles;
    logic [31:0] out_retired;
`endif

    int n_checks;
    int n_fail;
    vec_t vecs[$];

    multicycle_controller #(
        .MEM_WAIT_MAX (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_opcode        (in_opcode),
        .in_funct3        (in_funct3),
        .in_zero          (in_zero),
        .in_mem_ready     (in_mem_ready),
        .out_pc_write     (out_pc_write),
        .out_ir_write     (out_ir_write),
        .out_reg_write    (out_reg_write),
        .out_mem_read     (out_mem_read),
        .out_mem_write    (out_mem_write),
        .out_mem_sel_data (out_mem_sel_data),
        .out_alu_src_a    (out_alu_src_a),
        .out_alu_src_b    (out_alu_src_b),
        .out_alu_op       (out_alu_op),
        .out_result_src   (out_result_src),
        .out_fault        (out_fault),
        .out_state        (out_state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .out_cycles       (out_cycles),
        .out_retired      (out_retired)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t v(input logic [6:0] op, input logic [2:0] f3, input logic z,
                               input logic rdy, input logic [3:0] st, input logic [14:0] ctl);
        vec_t r;
        r.opcode    = op;
        r.funct3    = f3;
        r.zero      = z;
        r.ready     = rdy;
        r.exp_state = st;
        r.exp_ctl   = ctl;
        return r;
    endfunction

    function automatic logic [14:0] act_ctl();
        return {out_pc_write, out_ir_write, out_reg_write, out_mem_read, out_mem_write,
                out_mem_sel_data, out_alu_src_a, out_alu_src_b, out_alu_op,
                out_result_src, out_fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        rst          = 1'b0;
        in_mem_ready = 1'b1;
        in_opcode    = OP_R;
        #1;
        check("reset_state", 32'(out_state), 32'd0);
        check("reset_ctl", 32'(act_ctl()), 32'(C_FETCH));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic rdy);
        in_opcode    = op;
        in_funct3    = f3;
        in_zero      = z;
        in_mem_ready = rdy;
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        in_opcode    = 7'd0;
        in_funct3    = 3'd0;
        in_zero      = 1'b0;
        in_mem_ready = 1'b0;

        // R-type, I-type
        vecs.push_back(v(OP_R,   3'd0, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_R,   3'd0, 1'b0, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_R,   3'd0, 1'b0, 1'b1, 4'd6,  C_EXEC_R));
        vecs.push_back(v(OP_R,   3'd0, 1'b0, 1'b1, 4'd8,  C_ALU_WB));
        vecs.push_back(v(OP_I,   3'd0, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_I,   3'd0, 1'b0, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_I,   3'd0, 1'b0, 1'b1, 4'd7,  C_EXEC_I));
        vecs.push_back(v(OP_I,   3'd0, 1'b0, 1'b1, 4'd8,  C_ALU_WB));
        // LW with three wait cycles in MEM_READ: 8 cycles total
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b1, 4'd2,  C_MEM_ADDR));
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b0, 4'd3,  C_MEM_READ));
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b0, 4'd3,  C_MEM_READ));
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b0, 4'd3,  C_MEM_READ));
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b1, 4'd3,  C_MEM_READ));
        vecs.push_back(v(OP_LW,  3'd2, 1'b0, 1'b1, 4'd4,  C_MEM_WB));
        // SW with one fetch wait
        vecs.push_back(v(OP_SW,  3'd2, 1'b0, 1'b0, 4'd0,  C_FETCH));
        vecs.push_back(v(OP_SW,  3'd2, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_SW,  3'd2, 1'b0, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_SW,  3'd2, 1'b0, 1'b1, 4'd2,  C_MEM_ADDR));
        vecs.push_back(v(OP_SW,  3'd2, 1'b0, 1'b1, 4'd5,  C_MEM_WRITE));
        // BEQ taken, BNE not taken, BNE taken
        vecs.push_back(v(OP_BR,  3'd0, 1'b1, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_BR,  3'd0, 1'b1, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_BR,  3'd0, 1'b1, 1'b1, 4'd9,  C_BRANCH_TK));
        vecs.push_back(v(OP_BR,  3'd1, 1'b1, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_BR,  3'd1, 1'b1, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_BR,  3'd1, 1'b1, 1'b1, 4'd9,  C_BRANCH));
        vecs.push_back(v(OP_BR,  3'd1, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_BR,  3'd1, 1'b0, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_BR,  3'd1, 1'b0, 1'b1, 4'd9,  C_BRANCH_TK));
        // JAL
        vecs.push_back(v(OP_JAL, 3'd0, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_JAL, 3'd0, 1'b0, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_JAL, 3'd0, 1'b0, 1'b1, 4'd10, C_JAL));
        vecs.push_back(v(OP_JAL, 3'd0, 1'b0, 1'b1, 4'd8,  C_ALU_WB));
        // Branch with unsupported funct3 -> FAULT
        vecs.push_back(v(OP_BR,  3'd4, 1'b1, 1'b1, 4'd0,  C_FETCH_RDY));
        vecs.push_back(v(OP_BR,  3'd4, 1'b1, 1'b1, 4'd1,  C_DECODE));
        vecs.push_back(v(OP_BR,  3'd4, 1'b1, 1'b1, 4'd9,  C_BRANCH));
        vecs.push_back(v(OP_BR,  3'd4, 1'b1, 1'b1, 4'd11, C_FAULT));
        vecs.push_back(v(OP_R,   3'd0, 1'b0, 1'b1, 4'd11, C_FAULT));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].opcode, vecs[i].funct3, vecs[i].zero, vecs[i].ready);
            check($sformatf("vec%0d_state", i), 32'(out_state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_ctl", i), 32'(act_ctl()), 32'(vecs[i].exp_ctl));
            @(negedge clk);
        end

        // Illegal opcode: FAULT after DECODE, sticky for 100 cycles, cleared by reset
        do_reset();
        drive(OP_BAD, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(OP_BAD, 3'd0, 1'b0, 1'b1);
        check("bad_op_decode", 32'(out_state), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            drive(OP_R, 3'd0, 1'b0, 1'(i % 2));
            check("fault_sticky", 32'({out_state, act_ctl()}), 32'({4'd11, C_FAULT}));
            @(negedge clk);
        end
        do_reset();
        check("fault_cleared", 32'(out_fault), 32'd0);

        // Fetch timeout: 15 stalled cycles in FETCH, then FAULT
        for (int i = 0; i < 15; i++) begin
            drive(OP_R, 3'd0, 1'b0, 1'b0);
            check("fetch_wait", 32'(out_state), 32'd0);
            @(negedge clk);
        end
        drive(OP_R, 3'd0, 1'b0, 1'b0);
        check("fetch_timeout", 32'(out_state), 32'd11);
        check("fetch_timeout_flag", 32'(out_fault), 32'd1);

        // Ready on the 15th fetch cycle completes normally
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(OP_R, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(OP_R, 3'd0, 1'b0, 1'b1);
        check("fetch_last_ready", 32'(act_ctl()), 32'(C_FETCH_RDY));
        @(negedge clk);
        drive(OP_R, 3'd0, 1'b0, 1'b1);
        check("fetch_last_decode", 32'(out_state), 32'd1);
        @(negedge clk);

`ifdef MULTICYCLE_CTRL_PERF_EN
        // Ten back-to-back R-type instructions
        do_reset();
        check("perf_reset_cycles", out_cycles, 32'd0);
        check("perf_reset_retired", out_retired, 32'd0);
        for (int i = 0; i < 40; i++) begin
            drive(OP_R, 3'd0, 1'b0, 1'b1);
            @(negedge clk);
        end
        #1;
        check("perf_cycles", out_cycles, 32'd40);
        check("perf_retired", out_retired, 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
